row_accumulator: RTL

ROW_ACCUMULATOR -- requirements
Module: row_accumulator

---
 rtl/smvm_pkg.sv | 6 +
 rtl/counter_down.sv | 17 +
 rtl/row_accumulator.sv | 94 +++++++++
 3 files changed

// File: rtl/smvm_pkg.sv
// smvm_pkg: shared FSM state type and default widths for the row accumulator
package smvm_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} acc_state_e;
  localparam int SMVM_DATA_W = 32;
  localparam int SMVM_ACC_W = 40;
endpackage

// File: rtl/counter_down.sv
// counter_down: loadable down-counter tracking products still owed to the current row
module counter_down (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        clear,
  input  logic        set,
  input  logic [31:0] set_val,
  input  logic        en,
  output logic [31:0] cnt
);
  // clear beats load, load beats decrement
  always_ff @(posedge clk or negedge rst_l)
    if (!rst_l) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (set) cnt <= set_val;
    else if (en) cnt <= cnt - 32'd1;
endmodule

// File: rtl/row_accumulator.sv
// row_accumulator: sums a length-prefixed row of signed products; ROW_ACCUMULATOR_SATURATE_EN selects clamping
module row_accumulator
  import smvm_pkg::*;
#(
  parameter int DATA_W = SMVM_DATA_W,
  parameter int ACC_W  = SMVM_ACC_W
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     clear,
  input  logic                     len_valid,
  output logic                     len_ready,
  input  logic [31:0]              len,
  input  logic                     prod_valid,
  output logic                     prod_ready,
  input  logic signed [DATA_W-1:0] prod,
  output logic                     sum_valid,
  input  logic                     sum_ready,
  output logic signed [ACC_W-1:0]  sum,
  output logic [31:0]              row_cnt,
  output logic                     busy,
  output logic                     ovf
);
  acc_state_e state, state_nx;
  logic signed [ACC_W-1:0] acc, prod_x, acc_add, acc_nx;
  logic [31:0] remaining;
  logic len_hs, prod_hs, sum_hs;
  assign len_hs  = len_valid & len_ready;
  assign prod_hs = prod_valid & prod_ready;
  assign sum_hs  = sum_valid & sum_ready;
  assign prod_x  = prod;
  assign acc_add = acc + prod_x;
  assign sum     = acc;
  assign busy    = state != IDLE;
  counter_down u_rem (
    .clk     (clk),
    .rst_l   (rst_l),
    .clear   (clear),
    .set     (len_hs),
    .set_val (len),
    .en      (prod_hs),
    .cnt     (remaining)
  );
`ifdef ROW_ACCUMULATOR_SATURATE_EN
  logic add_ovf;
  assign add_ovf = (acc[ACC_W-1] == prod_x[ACC_W-1]) && (acc_add[ACC_W-1] != acc[ACC_W-1]);
  assign acc_nx  = add_ovf ? (acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}}) : acc_add;
  // overflow flag sticks until reset or clear
  always_ff @(posedge clk or negedge rst_l)
    if (!rst_l) ovf <= 1'b0;
    else if (clear) ovf <= 1'b0;
    else if (prod_hs && add_ovf) ovf <= 1'b1;
`else
  assign acc_nx = acc_add;
  assign ovf    = 1'b0;
`endif
  // state register
  always_ff @(posedge clk or negedge rst_l)
    if (!rst_l) state <= IDLE;
    else state <= state_nx;
  // next state; handshake readies/valid decoded from registered state only
  always_comb begin
    state_nx   = state;
    len_ready  = 1'b0;
    prod_ready = 1'b0;
    sum_valid  = 1'b0;
    case (state)
      IDLE: begin
        len_ready = 1'b1;
        if (len_valid) state_nx = (len == '0) ? EMIT : ACCUM;
      end
      ACCUM: begin
        prod_ready = 1'b1;
        if (prod_valid && remaining == 32'd1) state_nx = EMIT;
      end
      EMIT: begin
        sum_valid = 1'b1;
        if (sum_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (clear) state_nx = IDLE;
  end
  // accumulator: zeroed on a new row, updated per accepted product
  always_ff @(posedge clk or negedge rst_l)
    if (!rst_l) acc <= '0;
    else if (clear || len_hs) acc <= '0;
    else if (prod_hs) acc <= acc_nx;
  // completed-row counter, wraps naturally
  always_ff @(posedge clk or negedge rst_l)
    if (!rst_l) row_cnt <= '0;
    else if (clear) row_cnt <= '0;
    else if (sum_hs) row_cnt <= row_cnt + 32'd1;
endmodule
